// File: rtl/run_length_histogram_pkg.sv
// Shared types and helpers for the run-length histogram block.
package hist_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } frame_st_t;

    typedef enum logic {
        GAP,
        RUN
    } run_st_t;

    localparam int unsigned MODE_VALID = 0;
    localparam int unsigned MODE_ONES  = 1;

    // Run lengths beyond max_run all share the overflow bin 0.
    function automatic int unsigned bin_idx(input int unsigned len, input int unsigned max_run);
        return (len > max_run) ? 32'd0 : len;
    endfunction

endpackage

// File: rtl/run_length_histogram_if.sv
// Sample, frame-control and read-port signals of the run-length histogram.
interface run_length_histogram_if #(
    parameter int unsigned MAX_RUN = 16,
    parameter int unsigned CNT_W   = 10
);
    localparam int unsigned AW = $clog2(MAX_RUN + 1);

    logic             data_in;
    logic             data_valid;
    logic             hist_int;
    logic             rd_req;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] hist_data;
    logic             hist_valid;
    logic [CNT_W+3:0] run_total;
    logic             sat;
    logic             active;

    modport master (
        output data_in, data_valid, hist_int, rd_req, addr,
        input  hist_data, hist_valid, run_total, sat, active
    );

    modport slave (
        input  data_in, data_valid, hist_int, rd_req, addr,
        output hist_data, hist_valid, run_total, sat, active
    );

endinterface

// File: rtl/run_length_histogram_run_detector.sv
// Run FSM: tracks the current run length and flags its end for one cycle.
module hist_run_detector
    import hist_pkg::*;
#(
    parameter int unsigned MAX_RUN = 16,
    parameter int unsigned MODE    = MODE_VALID,
    localparam int unsigned LEN_W  = $clog2(MAX_RUN + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             data_in_i,
    input  logic             data_valid_i,
    output logic             run_done_o,
    output logic [LEN_W-1:0] run_len_o
);

    localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_RUN + 1);

    run_st_t          st_q, st_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             cond;

    assign cond = (MODE == MODE_ONES) ? (data_valid_i & data_in_i) : data_valid_i;

    always_comb begin
        st_d       = st_q;
        len_d      = len_q;
        run_done_o = 1'b0;
        run_len_o  = len_q;
        // A frame clear discards any open run and ignores this cycle's sample.
        if (clr_i) begin
            st_d  = GAP;
            len_d = '0;
        end else if (en_i) begin
            case (st_q)
                GAP: begin
                    if (cond) begin
                        st_d  = RUN;
                        len_d = LEN_W'(1);
                    end
                end
                RUN: begin
                    if (cond) begin
                        if (len_q != LenMax) begin
                            len_d = len_q + LEN_W'(1);
                        end
                    end else begin
                        st_d       = GAP;
                        len_d      = '0;
                        run_done_o = 1'b1;
                    end
                end
                default: st_d = GAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= GAP;
            len_q <= '0;
        end else begin
            st_q  <= st_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/run_length_histogram.sv
// Per-frame histogram of run lengths on a 1-bit sample stream, with a 2-cycle read port.
module run_length_histogram
    import hist_pkg::*;
#(
    parameter int unsigned MAX_RUN = 16,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned MODE    = MODE_VALID
) (
    input logic                   clk,
    input logic                   rst,
    run_length_histogram_if.slave hist_io
);

    localparam int unsigned AW    = $clog2(MAX_RUN + 1);
    localparam int unsigned LEN_W = $clog2(MAX_RUN + 2);
    localparam int unsigned TOT_W = CNT_W + 4;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [TOT_W-1:0] TotMax = '1;
    localparam logic [AW-1:0]    MaxIdx = AW'(MAX_RUN);

    frame_st_t        frame_q, frame_d;
    logic [CNT_W-1:0] bins_q [MAX_RUN+1];
    logic [CNT_W-1:0] bins_d [MAX_RUN+1];
    logic [TOT_W-1:0] total_q, total_d;
    logic             sat_q, sat_d;

    logic             run_en;
    logic             run_done;
    logic [LEN_W-1:0] run_len;
    logic [AW-1:0]    upd_idx;

    logic [CNT_W-1:0] rd_data;
    logic             rd_v1_q, rd_v2_q;
    logic [CNT_W-1:0] rd_d1_q, rd_d2_q;

    assign run_en  = (frame_q == ACTIVE);
    assign upd_idx = AW'(bin_idx(32'(run_len), MAX_RUN));

    hist_run_detector #(
        .MAX_RUN(MAX_RUN),
        .MODE   (MODE)
    ) u_run_det (
        .clk         (clk),
        .rst         (rst),
        .en_i        (run_en),
        .clr_i       (hist_io.hist_int),
        .data_in_i   (hist_io.data_in),
        .data_valid_i(hist_io.data_valid),
        .run_done_o  (run_done),
        .run_len_o   (run_len)
    );

    always_comb begin
        frame_d = frame_q;
        if (hist_io.hist_int) begin
            frame_d = ACTIVE;
        end
    end

    always_comb begin
        bins_d  = bins_q;
        total_d = total_q;
        sat_d   = sat_q;
        if (hist_io.hist_int) begin
            for (int i = 0; i <= int'(MAX_RUN); i++) begin
                bins_d[i] = '0;
            end
            total_d = '0;
            sat_d   = 1'b0;
        end else if (run_done) begin
            if (bins_q[upd_idx] == CntMax) begin
                sat_d = 1'b1;
            end else begin
                bins_d[upd_idx] = bins_q[upd_idx] + CNT_W'(1);
            end
            if (total_q == TotMax) begin
                sat_d = 1'b1;
            end else begin
                total_d = total_q + TOT_W'(1);
            end
        end
    end

    // Reads sample the registered bins, so same-cycle updates and clears are not visible.
    always_comb begin
        rd_data = '0;
        if (hist_io.rd_req && (hist_io.addr <= MaxIdx)) begin
            rd_data = bins_q[hist_io.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= IDLE;
            for (int i = 0; i <= int'(MAX_RUN); i++) begin
                bins_q[i] <= '0;
            end
            total_q <= '0;
            sat_q   <= 1'b0;
            rd_v1_q <= 1'b0;
            rd_d1_q <= '0;
            rd_v2_q <= 1'b0;
            rd_d2_q <= '0;
        end else begin
            frame_q <= frame_d;
            bins_q  <= bins_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            rd_v1_q <= hist_io.rd_req;
            rd_d1_q <= rd_data;
            rd_v2_q <= rd_v1_q;
            rd_d2_q <= rd_d1_q;
        end
    end

    assign hist_io.hist_data  = rd_d2_q;
    assign hist_io.hist_valid = rd_v2_q;
    assign hist_io.run_total  = total_q;
    assign hist_io.sat        = sat_q;
    assign hist_io.active     = run_en;

endmodule

// File: tb/tb_run_length_histogram.sv
// Directed bench: three configurations share one stimulus stream and read port.
module tb_run_length_histogram;

    logic       clk;
    logic       rst;
    logic       di;
    logic       dv;
    logic       hint;
    logic       rd_req;
    logic [4:0] addr;

    int n_vec;
    int n_err;

    // a: defaults, b: CNT_W=2, c: MODE=1
    run_length_histogram_if #(.MAX_RUN(16), .CNT_W(10)) if_a ();
    run_length_histogram_if #(.MAX_RUN(16), .CNT_W(2))  if_b ();
    run_length_histogram_if #(.MAX_RUN(16), .CNT_W(10)) if_c ();

    assign if_a.data_in = di;  assign if_a.data_valid = dv;  assign if_a.hist_int = hint;
    assign if_a.rd_req = rd_req;  assign if_a.addr = addr;
    assign if_b.data_in = di;  assign if_b.data_valid = dv;  assign if_b.hist_int = hint;
    assign if_b.rd_req = rd_req;  assign if_b.addr = addr;
    assign if_c.data_in = di;  assign if_c.data_valid = dv;  assign if_c.hist_int = hint;
    assign if_c.rd_req = rd_req;  assign if_c.addr = addr;

    run_length_histogram #(.MAX_RUN(16), .CNT_W(10), .MODE(0)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .hist_io(if_a)
    );
    run_length_histogram #(.MAX_RUN(16), .CNT_W(2), .MODE(0)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .hist_io(if_b)
    );
    run_length_histogram #(.MAX_RUN(16), .CNT_W(10), .MODE(1)) u_dut_c (
        .clk    (clk),
        .rst    (rst),
        .hist_io(if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hist_pulse();
        hint = 1'b1;
        step();
        hint = 1'b0;
    endtask

    // n valid cycles followed by a one-cycle gap that closes the run.
    task automatic run(input int n);
        dv = 1'b1;
        repeat (n) step();
        dv = 1'b0;
        step();
    endtask

    task automatic rd_bin(input logic [4:0] a, output logic [31:0] da, output logic [31:0] db,
                          output logic [31:0] dc);
        rd_req = 1'b1;
        addr   = a;
        step();
        rd_req = 1'b0;
        step();
        check_eq("rd_valid", 32'(if_a.hist_valid), 32'd1);
        da = 32'(if_a.hist_data);
        db = 32'(if_b.hist_data);
        dc = 32'(if_c.hist_data);
    endtask

    initial begin
        logic [31:0] da, db, dc;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        di     = 1'b0;
        dv     = 1'b0;
        hint   = 1'b0;
        rd_req = 1'b0;
        addr   = '0;
        repeat (3) step();
        rst = 1'b0;

        check_eq("rst_hist_data", 32'(if_a.hist_data), 32'd0);
        check_eq("rst_hist_valid", 32'(if_a.hist_valid), 32'd0);
        check_eq("rst_run_total", 32'(if_a.run_total), 32'd0);
        check_eq("rst_sat", 32'(if_a.sat), 32'd0);
        check_eq("rst_active", 32'(if_a.active), 32'd0);

        // IDLE ignores samples
        run(3);
        rd_bin(5'd3, da, db, dc);
        check_eq("idle_bin3", da, 32'd0);
        check_eq("idle_total", 32'(if_a.run_total), 32'd0);
        check_eq("idle_active", 32'(if_a.active), 32'd0);

        // Basic frame: runs 2,3,1,8,2
        hist_pulse();
        check_eq("active", 32'(if_a.active), 32'd1);
        run(2); run(3); run(1); run(8); run(2);
        check_eq("t1_total", 32'(if_a.run_total), 32'd5);
        check_eq("t1_sat", 32'(if_a.sat), 32'd0);
        rd_bin(5'd2, da, db, dc);  check_eq("t1_bin2", da, 32'd2);
        rd_bin(5'd3, da, db, dc);  check_eq("t1_bin3", da, 32'd1);
        rd_bin(5'd1, da, db, dc);  check_eq("t1_bin1", da, 32'd1);
        rd_bin(5'd8, da, db, dc);  check_eq("t1_bin8", da, 32'd1);
        rd_bin(5'd4, da, db, dc);  check_eq("t1_bin4", da, 32'd0);

        // Overflow bin
        hist_pulse();
        run(20);
        rd_bin(5'd0, da, db, dc);  check_eq("ovf_bin0", da, 32'd1);
        rd_bin(5'd16, da, db, dc); check_eq("ovf_bin16", da, 32'd0);
        check_eq("ovf_total", 32'(if_a.run_total), 32'd1);

        // Saturation on the 2-bit instance
        hist_pulse();
        repeat (5) run(1);
        rd_bin(5'd1, da, db, dc);
        check_eq("sat_bin1_b", db, 32'd3);
        check_eq("sat_bin1_a", da, 32'd5);
        check_eq("sat_flag_b", 32'(if_b.sat), 32'd1);
        check_eq("sat_flag_a", 32'(if_a.sat), 32'd0);
        check_eq("sat_total_b", 32'(if_b.run_total), 32'd5);
        hist_pulse();
        check_eq("clr_sat_b", 32'(if_b.sat), 32'd0);
        rd_bin(5'd1, da, db, dc);
        check_eq("clr_bin1_b", db, 32'd0);

        // MODE=1 runs of ones: 1,1,0,1,1,1,0
        hist_pulse();
        dv = 1'b1;
        for (int i = 0; i < 7; i++) begin
            di = (i == 2 || i == 6) ? 1'b0 : 1'b1;
            step();
        end
        dv = 1'b0;
        di = 1'b0;
        step();
        rd_bin(5'd2, da, db, dc);  check_eq("ones_bin2", dc, 32'd1);
        rd_bin(5'd3, da, db, dc);  check_eq("ones_bin3", dc, 32'd1);
        check_eq("ones_total", 32'(if_c.run_total), 32'd2);
        rd_bin(5'd7, da, db, dc);  check_eq("valid_bin7", da, 32'd1);

        // hist_int in cycle 4 of a 6-cycle run, with reads at the clear cycle and the next
        hist_pulse();
        run(2);
        dv = 1'b1;
        step(); step(); step();
        hint   = 1'b1;
        rd_req = 1'b1;
        addr   = 5'd2;
        step();
        hint = 1'b0;
        step();
        rd_req = 1'b0;
        check_eq("preclr_valid", 32'(if_a.hist_valid), 32'd1);
        check_eq("preclr_data", 32'(if_a.hist_data), 32'd1);
        step();
        check_eq("postclr_valid", 32'(if_a.hist_valid), 32'd1);
        check_eq("postclr_data", 32'(if_a.hist_data), 32'd0);
        dv = 1'b0;
        step();
        rd_bin(5'd2, da, db, dc);  check_eq("midclr_bin2", da, 32'd1);
        rd_bin(5'd3, da, db, dc);  check_eq("midclr_bin3", da, 32'd0);
        check_eq("midclr_total", 32'(if_a.run_total), 32'd1);

        // Back-to-back reads: addr 2, 31, 2
        step();
        for (int i = 0; i < 6; i++) begin
            check_eq("b2b_valid", 32'(if_a.hist_valid), (i >= 2 && i < 5) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 5) begin
                check_eq("b2b_data", 32'(if_a.hist_data), (i == 3) ? 32'd0 : 32'd1);
            end
            rd_req = (i < 3) ? 1'b1 : 1'b0;
            addr   = (i == 1) ? 5'd31 : 5'd2;
            step();
        end
        rd_req = 1'b0;

        // Reset between request and response
        rd_req = 1'b1;
        addr   = 5'd2;
        step();
        rd_req = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstrd_valid", 32'(if_a.hist_valid), 32'd0);
        check_eq("rstrd_data", 32'(if_a.hist_data), 32'd0);
        check_eq("rstrd_total", 32'(if_a.run_total), 32'd0);
        check_eq("rstrd_sat", 32'(if_a.sat), 32'd0);
        check_eq("rstrd_active", 32'(if_a.active), 32'd0);
        step();
        check_eq("rstrd_valid2", 32'(if_a.hist_valid), 32'd0);
        rd_bin(5'd2, da, db, dc);  check_eq("rstrd_bin2", da, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
